// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Deserialises adcdat framed by adclrc on the codec bit
// clock into {left, right} stereo words and queues them in a single-clock FIFO.
//
// Handshake: a word is written into the FIFO on the rising bclk edge that
// samples the right-channel LSB, unless the FIFO is full, in which case it is
// dropped and overflow is set. The consumer pops by holding adcfifo_rden high
// for one edge while adcfifo_empty is low. adcfifo_rddata presents the popped
// word after that edge. A pop request while empty is ignored and rddata holds.
//
// The FSM state is exposed on state_dbg so checkers can bind to it.
module i2s_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          bclk,
    input  logic                          reset_n,
    input  logic                          adclrc,
    input  logic                          adcdat,
    input  logic                          adcfifo_rden,
    output logic [DATA_WIDTH-1:0]         adcfifo_rddata,
    output logic                          adcfifo_empty,
    output logic                          adcfifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   adcfifo_usedw,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [2:0]                    state_dbg
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEFT       = 3'd1,
        S_LEFT_WAIT  = 3'd2,
        S_RIGHT      = 3'd3,
        S_RIGHT_WAIT = 3'd4,
        S_RIGHT_HOLD = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Channel-select edge detection
    // ------------------------------------------------------------------
    logic adclrc_r0;
    logic fall;
    logic rise;

    // Previous adclrc sample; reset to 0 so a fall needs a real high first.
    always_ff @(posedge bclk) begin
        if (!reset_n) adclrc_r0 <= 1'b0;
        else          adclrc_r0 <= adclrc;
    end

    assign fall = adclrc_r0 & ~adclrc;
    assign rise = ~adclrc_r0 & adclrc;

    // ------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [CW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [HALF-1:0]     left_sr, left_nxt;
    logic [HALF-1:0]     right_sr, right_nxt;
    logic                push;
    logic                err_set;
    logic [DATA_WIDTH-1:0] push_data;

    // State, bit counter, shift registers and the sticky framing error.
    always_ff @(posedge bclk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            left_sr   <= '0;
            right_sr  <= '0;
            frame_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            left_sr  <= left_nxt;
            right_sr <= right_nxt;
            if (err_set) frame_err <= 1'b1;
        end
    end

    // Next-state logic. An edge cycle is always the one-bit delay slot, so
    // reloading bit_cnt on an edge means adcdat of that cycle is skipped.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        left_nxt    = left_sr;
        right_nxt   = right_sr;
        push        = 1'b0;
        err_set     = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt   = S_LEFT;
                    bit_cnt_nxt = HALF_CNT;
                end
            end
            S_LEFT: begin
                if (fall) begin
                    // Left restarted early: this cycle is the new delay slot.
                    err_set     = 1'b1;
                    bit_cnt_nxt = HALF_CNT;
                end else if (rise) begin
                    // Left cut short: drop it and skip the right channel.
                    err_set     = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_RIGHT_HOLD;
                end else begin
                    left_nxt    = {left_sr[HALF-2:0], adcdat};
                    bit_cnt_nxt = bit_cnt - ONE_CNT;
                    if (bit_cnt == ONE_CNT) state_nxt = S_LEFT_WAIT;
                end
            end
            S_LEFT_WAIT: begin
                if (rise) begin
                    state_nxt   = S_RIGHT;
                    bit_cnt_nxt = HALF_CNT;
                end
            end
            S_RIGHT: begin
                if (fall) begin
                    err_set     = 1'b1;
                    state_nxt   = S_LEFT;
                    bit_cnt_nxt = HALF_CNT;
                end else begin
                    right_nxt   = {right_sr[HALF-2:0], adcdat};
                    bit_cnt_nxt = bit_cnt - ONE_CNT;
                    if (bit_cnt == ONE_CNT) begin
                        push      = 1'b1;
                        state_nxt = S_RIGHT_WAIT;
                    end
                end
            end
            S_RIGHT_WAIT, S_RIGHT_HOLD: begin
                if (fall) begin
                    state_nxt   = S_LEFT;
                    bit_cnt_nxt = HALF_CNT;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    // The right LSB is taken straight from adcdat so the word is pushed on
    // the very edge that samples it.
    assign push_data = {left_sr, right_sr[HALF-2:0], adcdat};
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign adcfifo_empty = (adcfifo_usedw == '0);
    assign adcfifo_full  = (adcfifo_usedw == FULL_CNT);
    assign push_ok       = push & ~adcfifo_full;
    assign pop_ok        = adcfifo_rden & ~adcfifo_empty;

    // Storage array; reset only flushes by clearing the pointers.
    always_ff @(posedge bclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy, registered read data and sticky overflow.
    always_ff @(posedge bclk) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            adcfifo_usedw  <= '0;
            adcfifo_rddata <= '0;
            overflow       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr         <= rd_ptr + AW'(1);
                adcfifo_rddata <= mem[rd_ptr];
            end
            adcfifo_usedw <= adcfifo_usedw + {{AW{1'b0}}, push_ok}
                                           - {{AW{1'b0}}, pop_ok};
            if (push && adcfifo_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx with hand-computed expected words.
module tb_i2s_rx;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int HALF  = DW / 2;

  logic          bclk;
  logic          reset_n;
  logic          adclrc;
  logic          adcdat;
  logic          adcfifo_rden;
  logic [DW-1:0] adcfifo_rddata;
  logic          adcfifo_empty;
  logic          adcfifo_full;
  logic [6:0]    adcfifo_usedw;
  logic          overflow;
  logic          frame_err;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  i2s_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .bclk           (bclk),
    .reset_n        (reset_n),
    .adclrc         (adclrc),
    .adcdat         (adcdat),
    .adcfifo_rden   (adcfifo_rden),
    .adcfifo_rddata (adcfifo_rddata),
    .adcfifo_empty  (adcfifo_empty),
    .adcfifo_full   (adcfifo_full),
    .adcfifo_usedw  (adcfifo_usedw),
    .overflow       (overflow),
    .frame_err      (frame_err),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic drive_bit(input logic lrc, input logic dat, input logic rd);
    @(negedge bclk);
    adclrc       = lrc;
    adcdat       = dat;
    adcfifo_rden = rd;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n,
                            input logic junk, input logic pop_at_lsb);
    for (int i = 0; i < n; i++)
      drive_bit(1'b0, (i >= 1 && i <= HALF) ? l[HALF-i] : junk, 1'b0);
    for (int i = 0; i < n; i++)
      drive_bit(1'b1, (i >= 1 && i <= HALF) ? r[HALF-i] : junk, pop_at_lsb && (i == HALF));
    @(negedge bclk);
    adcfifo_rden = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [DW-1:0] exp;
    @(negedge bclk);
    adcfifo_rden = 1'b1;
    @(negedge bclk);
    adcfifo_rden = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check(tag, adcfifo_rddata, exp);
  endtask

  initial begin
    logic [15:0] kk;
    reset_n      = 1'b0;
    adclrc       = 1'b1;
    adcdat       = 1'b0;
    adcfifo_rden = 1'b0;
    repeat (3) @(negedge bclk);
    reset_n = 1'b1;

    // reset state
    check("rst_rddata", adcfifo_rddata, 32'h0);
    check("rst_empty", 32'(adcfifo_empty), 32'd1);
    check("rst_full", 32'(adcfifo_full), 32'd0);
    check("rst_usedw", 32'(adcfifo_usedw), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // basic 17-bclk frame, junk 1 in delay slot
    send_frame(16'hA55A, 16'h1234, 17, 1'b1, 1'b0);
    exp_q.push_back(32'hA55A1234);
    check("basic_usedw", 32'(adcfifo_usedw), 32'd1);
    check("basic_empty", 32'(adcfifo_empty), 32'd0);
    pop_check("basic_word");
    check("basic_empty_after", 32'(adcfifo_empty), 32'd1);

    // 32 bclk per channel with trailing junk ones
    send_frame(16'h0001, 16'h8000, 32, 1'b1, 1'b0);
    exp_q.push_back(32'h00018000);
    send_frame(16'hFFFF, 16'h0000, 32, 1'b1, 1'b0);
    exp_q.push_back(32'hFFFF0000);
    send_frame(16'h7FFE, 16'h1357, 32, 1'b1, 1'b0);
    exp_q.push_back(32'h7FFE1357);
    check("long_usedw", 32'(adcfifo_usedw), 32'd3);
    check("long_ferr", 32'(frame_err), 32'd0);
    pop_check("long_w0");
    pop_check("long_w1");
    pop_check("long_w2");

    // short left channel: rise after 10 bits, then a good frame
    drive_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive_bit(1'b0, i[0], 1'b0);
    for (int i = 0; i < 17; i++) drive_bit(1'b1, 1'b1, 1'b0);
    send_frame(16'hCAFE, 16'hBEEF, 17, 1'b0, 1'b0);
    exp_q.push_back(32'hCAFEBEEF);
    check("short_ferr", 32'(frame_err), 32'd1);
    check("short_usedw", 32'(adcfifo_usedw), 32'd1);
    pop_check("short_word");
    check("short_empty", 32'(adcfifo_empty), 32'd1);

    // 65 frames, no reads: word 64 is dropped
    for (int k = 0; k < 65; k++) begin
      kk = 16'(k);
      send_frame(kk, ~kk, 17, 1'b0, 1'b0);
      if (k < DEPTH) exp_q.push_back({kk, ~kk});
    end
    check("ovf_usedw", 32'(adcfifo_usedw), 32'd64);
    check("ovf_full", 32'(adcfifo_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) pop_check($sformatf("ovf_word%0d", k));
    check("ovf_empty", 32'(adcfifo_empty), 32'd1);
    check("ovf_full_clr", 32'(adcfifo_full), 32'd0);

    // rden held while empty: rddata keeps last word {63, ~63}
    repeat (3) begin
      @(negedge bclk);
      adcfifo_rden = 1'b1;
    end
    @(negedge bclk);
    adcfifo_rden = 1'b0;
    check("uflow_rddata", adcfifo_rddata, 32'h003FFFC0);
    check("uflow_usedw", 32'(adcfifo_usedw), 32'd0);
    check("uflow_empty", 32'(adcfifo_empty), 32'd1);

    // simultaneous push and pop at usedw = 3
    send_frame(16'h1111, 16'h2222, 17, 1'b0, 1'b0);
    send_frame(16'h3333, 16'h4444, 17, 1'b0, 1'b0);
    send_frame(16'h5555, 16'h6666, 17, 1'b0, 1'b0);
    exp_q.push_back(32'h11112222);
    exp_q.push_back(32'h33334444);
    exp_q.push_back(32'h55556666);
    check("pp_usedw_before", 32'(adcfifo_usedw), 32'd3);
    send_frame(16'h7777, 16'h8888, 17, 1'b0, 1'b1);
    exp_q.push_back(32'h77778888);
    check("pp_usedw_after", 32'(adcfifo_usedw), 32'd3);
    check("pp_rddata", adcfifo_rddata, exp_q.pop_front());
    pop_check("pp_w1");
    check("pp_usedw_two", 32'(adcfifo_usedw), 32'd2);

    // reset mid-right-channel with 2 words queued
    for (int i = 0; i < 17; i++) drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b1, 1'b0);
    @(negedge bclk);
    reset_n = 1'b0;
    @(negedge bclk);
    reset_n = 1'b1;
    exp_q.delete();
    check("mrst_usedw", 32'(adcfifo_usedw), 32'd0);
    check("mrst_empty", 32'(adcfifo_empty), 32'd1);
    check("mrst_full", 32'(adcfifo_full), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_ferr", 32'(frame_err), 32'd0);
    check("mrst_rddata", adcfifo_rddata, 32'h0);
    check("mrst_state", 32'(state_dbg), 32'd0);
    send_frame(16'h0F0F, 16'hF00F, 17, 1'b1, 1'b0);
    exp_q.push_back(32'h0F0FF00F);
    check("mrst_usedw_after", 32'(adcfifo_usedw), 32'd1);
    pop_check("mrst_word");
    check("mrst_empty_after", 32'(adcfifo_empty), 32'd1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive side of the audio I2S link. It deserialises ADC data (adcdat) framed by adclrc on the codec's bit clock into 32-bit stereo words {left[15:0], right[15:0]}. It buffers them in an internal single-clock FIFO for the processing chain. The word layout is identical to what i2s_tx consumes, so rx→tx loopback needs no repacking.

## Interface
Parameters:
- DATA_WIDTH, 32, stereo word width; each channel is DATA_WIDTH/2 bits, MSB first
- FIFO_DEPTH, 64, FIFO word count; power of two ≥ 4

Ports:
- bclk  in  1  codec bit clock; the only clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset (sampled on rising bclk)
- adclrc  in  1  channel select; low = left, high = right
- adcdat  in  1  serial data, sampled on rising bclk
- adcfifo_rden  in  1  pop request
- adcfifo_rddata  out  DATA_WIDTH  popped word, registered
- adcfifo_empty  out  1  FIFO holds 0 words
- adcfifo_full  out  1  FIFO holds FIFO_DEPTH words
- adcfifo_usedw  out  $clog2(FIFO_DEPTH)+1  words stored
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- frame_err  out  1  sticky: a channel ended before DATA_WIDTH/2 bits were received

## Operation
- Edge detect: adclrc_r0 holds the previous sample of adclrc.
  - fall = adclrc_r0 & ~adclrc
  - rise = ~adclrc_r0 & adclrc
  - adclrc_r0 resets to 0.
- I2S one-bit delay: the cycle an edge is detected is the delay slot, and its adcdat is ignored. The next DATA_WIDTH/2 cycles sample MSB..LSB into the channel shift register.
- States:
  - IDLE: wait for fall → LEFT, bit_cnt = DATA_WIDTH/2.
  - LEFT: shift adcdat in and decrement bit_cnt.
    - After the LSB → LEFT_WAIT.
    - rise before completion → frame_err=1, discard, go to RIGHT_HOLD.
    - fall before completion → frame_err=1, restart LEFT (this cycle is the new delay slot).
  - LEFT_WAIT: ignore extra bits; rise → RIGHT, bit_cnt reloaded.
  - RIGHT: same as LEFT.
    - After the LSB, push {left,right} and go to RIGHT_WAIT.
    - fall before completion → frame_err=1, no push, restart LEFT.
  - RIGHT_WAIT / RIGHT_HOLD: ignore bits; fall → LEFT.
- Extra bclk per channel (e.g. 32 per channel): the trailing bits are ignored.
- FIFO push/pop rules:
  - Push while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - rden while empty is ignored and rddata holds its value.
  - Push while empty with rden: the pop is ignored and the push is accepted.
  - Otherwise a simultaneous push and pop leaves usedw unchanged.
- Pointers wrap modulo FIFO_DEPTH; usedw never exceeds FIFO_DEPTH.
- Reset values:
  - state = IDLE, bit_cnt = 0, shift registers = 0
  - adcfifo_rddata = 0, adcfifo_empty = 1, adcfifo_full = 0, adcfifo_usedw = 0
  - overflow = 0, frame_err = 0
- Reset mid-frame discards the partial word and flushes the FIFO. The first word after reset requires a fresh fall.

## Timing
- Push happens on the rising edge that samples the right LSB. empty/usedw/full reflect the push from the next cycle.
- Latency from first left MSB sample to word visible: DATA_WIDTH/2 + delay-slot + DATA_WIDTH/2 cycles, plus 1 cycle for flags.
- Pop: rden high at edge N → rddata valid after edge N, i.e. a one-cycle read latency. usedw decrements at the same edge.
- Sticky flags set on the edge of the offending event and clear only on reset.
- Minimum supported frame: 2*(DATA_WIDTH/2+1) bclk.

## Test plan
- Basic frame, 17 bclk per channel: left 0xA55A, right 0x1234 → one push, rddata 0xA55A1234 one cycle after rden; empty returns to 1.
- 32 bclk per channel, three frames (0x0001/0x8000, 0xFFFF/0x0000, 0x7FFE/0x1357) with trailing junk bits 1 → words 0x00018000, 0xFFFF0000, 0x7FFE1357 in order; frame_err = 0.
- Short left channel (rise after 10 bits) followed by a good frame 0xCAFE/0xBEEF → frame_err = 1; FIFO holds only 0xCAFEBEEF.
- 65 frames with no reads, word k = {k,~k} → usedw = 64, full = 1, overflow = 1. Reads return words 0..63; word 64 is lost.
- rden held while empty, plus simultaneous push/pop at usedw = 3 → no underflow and rddata unchanged while empty; usedw stays 3.
- reset_n low for 1 cycle mid-right-channel with 2 words queued → usedw = 0, empty = 1, flags 0. The next full frame is received correctly.
